// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a length-prefixed 24-bit word stream,
// writes words from address 0 and releases the core from reset once the XOR checksum matches.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start after reset; core held in reset
// S_LEN_HI| expecting length high byte
// S_LEN_LO| expecting length low byte; length checked against memory size
// S_DATA  | collecting 3-byte big-endian words and writing them
// S_CSUM  | expecting checksum byte
// S_DONE  | load verified; core released from reset
// S_ERROR | load aborted (oversize or checksum mismatch); core held in reset
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [23:0]       imem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [32:0] MAX_N = 33'(1) << ADDR_W;

    state_t      state;
    state_t      state_next;

    logic [15:0] n_len;
    logic [1:0]  byte_idx;
    logic [7:0]  byte0;
    logic [7:0]  byte1;
    logic [7:0]  csum;

    logic        accept;
    logic        start_ok;
    logic [15:0] len_full;
    logic        oversize;
    logic        last_word;

    assign accept    = in_valid && in_ready;
    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign len_full  = {n_len[15:8], in_data};
    assign oversize  = 33'(len_full) > MAX_N;
    assign last_word = (word_count + 16'd1) == n_len;

    // Status outputs are pure decodes of the registered state.
    always_comb begin
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        core_reset = 1'b1;
        case (state)
            S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_DONE: begin
                done       = 1'b1;
                core_reset = 1'b0;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    state_next = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    if (oversize) begin
                        state_next = S_ERROR;
                    end else if (len_full == 16'd0) begin
                        state_next = S_CSUM;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && (byte_idx == 2'd2) && last_word) begin
                    state_next = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_next = (in_data == csum) ? S_DONE : S_ERROR;
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    state_next = S_LEN_HI;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_len      <= 16'd0;
            byte_idx   <= 2'd0;
            byte0      <= 8'd0;
            byte1      <= 8'd0;
            csum       <= 8'd0;
            word_count <= 16'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 24'd0;
        end else begin
            imem_we <= 1'b0;
            if (start_ok) begin
                n_len      <= 16'd0;
                byte_idx   <= 2'd0;
                csum       <= 8'd0;
                word_count <= 16'd0;
            end else if (accept) begin
                case (state)
                    S_LEN_HI: begin
                        n_len[15:8] <= in_data;
                        csum        <= csum ^ in_data;
                    end
                    S_LEN_LO: begin
                        n_len[7:0] <= in_data;
                        csum       <= csum ^ in_data;
                    end
                    S_DATA: begin
                        csum <= csum ^ in_data;
                        case (byte_idx)
                            2'd0: begin
                                byte0    <= in_data;
                                byte_idx <= 2'd1;
                            end
                            2'd1: begin
                                byte1    <= in_data;
                                byte_idx <= 2'd2;
                            end
                            default: begin
                                // Third byte completes the word; strobe it next cycle.
                                imem_we    <= 1'b1;
                                imem_addr  <= word_count[ADDR_W-1:0];
                                imem_wdata <= {byte0, byte1, in_data};
                                word_count <= word_count + 16'd1;
                                byte_idx   <= 2'd0;
                            end
                        endcase
                    end
                    default: begin
                        csum <= csum;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and randomized loads checked against a stream-level
// reference model of expected writes, accepted byte count and final status.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int MAX_WORDS = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [23:0]       imem_wdata;
    logic              core_reset;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       word_count;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  strm[$];
    int          exp_acc;
    int          exp_wc;
    bit          exp_done;
    bit          b2b_seen;
    bit          both_seen;
    logic        prev_we = 1'b0;

    always @(negedge clk) begin
        if (imem_we) got_q.push_back({imem_addr, imem_wdata});
        if (imem_we && prev_we) b2b_seen = 1'b1;
        if (done && error) both_seen = 1'b1;
        prev_we = imem_we;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // gap_mode: 0 = back-to-back, 1 = idle cycle before every byte, 2 = random gaps
    task automatic send(input logic [7:0] s[$], input int gap_mode, output int acc);
        acc = 0;
        foreach (s[i]) begin
            if (gap_mode == 1) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                tick();
            end else if (gap_mode == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    tick();
                end
            end
            if (!in_ready) break;
            in_valid = 1'b1;
            in_data  = s[i];
            tick();
            acc++;
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // Reference: what a stream should produce, derived from the framing rules.
    task automatic model(input logic [7:0] s[$]);
        int          n;
        logic [7:0]  x;
        exp_q.delete();
        n = {s[0], s[1]};
        if (n > MAX_WORDS) begin
            exp_acc  = 2;
            exp_wc   = 0;
            exp_done = 1'b0;
            return;
        end
        x = s[0] ^ s[1];
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({8'(k), s[2 + 3*k], s[3 + 3*k], s[4 + 3*k]});
            x = x ^ s[2 + 3*k] ^ s[3 + 3*k] ^ s[4 + 3*k];
        end
        exp_acc  = 3 + 3 * n;
        exp_wc   = n;
        exp_done = (s[2 + 3*n] == x);
    endtask

    task automatic make_stream(input int n, input bit bad);
        logic [7:0] x;
        logic [7:0] b;
        strm.delete();
        strm.push_back(8'(n >> 8));
        strm.push_back(8'(n));
        x = strm[0] ^ strm[1];
        for (int k = 0; k < 3 * n; k++) begin
            b = 8'($urandom);
            strm.push_back(b);
            x = x ^ b;
        end
        if (bad) x = x ^ 8'($urandom_range(1, 255));
        strm.push_back(x);
    endtask

    task automatic finish_checks(input string tag, input int acc);
        chk({tag, "_acc"},        acc,              exp_acc);
        chk({tag, "_done"},       done,             exp_done);
        chk({tag, "_error"},      error,            !exp_done);
        chk({tag, "_core_reset"}, core_reset,       !exp_done);
        chk({tag, "_busy"},       busy,             0);
        chk({tag, "_in_ready"},   in_ready,         0);
        chk({tag, "_word_count"}, word_count,       exp_wc);
        chk({tag, "_nwrites"},    got_q.size(),     exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, "_no_b2b"},     b2b_seen,         0);
    endtask

    task automatic run_load(input string tag, input int gap_mode);
        int acc;
        got_q.delete();
        b2b_seen = 1'b0;
        model(strm);
        do_start();
        chk({tag, "_st_ready"},      in_ready,   1);
        chk({tag, "_st_busy"},       busy,       1);
        chk({tag, "_st_core_reset"}, core_reset, 1);
        chk({tag, "_st_done"},       done,       0);
        chk({tag, "_st_wc"},         word_count, 0);
        send(strm, gap_mode, acc);
        finish_checks(tag, acc);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},   in_ready,   0);
        chk({tag, "_imem_we"},    imem_we,    0);
        chk({tag, "_busy"},       busy,       0);
        chk({tag, "_done"},       done,       0);
        chk({tag, "_error"},      error,      0);
        chk({tag, "_core_reset"}, core_reset, 1);
        chk({tag, "_imem_addr"},  imem_addr,  0);
        chk({tag, "_imem_wdata"}, imem_wdata, 0);
        chk({tag, "_word_count"}, word_count, 0);
    endtask

    initial begin
        int acc;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) tick();
        chk_reset_vals("rst");
        reset = 1'b0;
        tick();
        chk_reset_vals("rst_idle");

        strm = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'hFB};
        run_load("normal", 0);

        strm = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'hFA};
        run_load("badcsum", 0);

        strm = '{8'h00, 8'h00, 8'h00};
        run_load("empty", 0);

        strm = '{8'h01, 8'h01, 8'h11, 8'h22, 8'h33};
        run_load("oversize", 0);

        strm = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'hFB};
        run_load("gaps", 1);

        // Reset in the middle of a load, then a clean reload from address 0.
        do_start();
        strm = '{8'h00, 8'h02, 8'h12, 8'h34};
        send(strm, 0, acc);
        chk("midrst_acc", acc, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_vals("midrst");
        strm = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'hFB};
        run_load("after_rst", 0);

        // start while in LEN_LO must not restart the load.
        strm = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'hFB};
        model(strm);
        got_q.delete();
        b2b_seen = 1'b0;
        do_start();
        strm = '{8'h00};
        send(strm, 0, acc);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("lenlo_start_busy", busy, 1);
        strm = '{8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'hFB};
        send(strm, 0, acc);
        finish_checks("lenlo_start", acc + 1);

        // Restart straight out of DONE.
        strm = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h07, 8'h06};
        run_load("restart", 0);

        // Largest legal program: exactly 2**ADDR_W words.
        make_stream(MAX_WORDS, 1'b0);
        run_load("maxlen", 0);

        make_stream($urandom_range(MAX_WORDS + 1, 65535), 1'b0);
        run_load("rand_oversize", 2);

        for (int t = 0; t < 8; t++) begin
            make_stream($urandom_range(0, 6), ($urandom_range(0, 3) == 0));
            run_load($sformatf("rand%0d", t), 2 * int'($urandom_range(0, 1)));
        end

        chk("never_done_and_error", both_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the processor's instruction memory. It accepts a byte stream carrying a length header, 24-bit instruction words and an XOR checksum, and writes each assembled word into instruction memory at consecutive addresses starting from 0. It holds the core in reset for the whole load and releases it only after the checksum verifies.

## Interface
- `ADDR_W`, default 8: instruction-memory address width; maximum load is 2**ADDR_W words.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle pulse that begins a load.
- `in_valid` in 1: `in_data` is valid this cycle.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader accepts a byte this cycle.
- `imem_we` out 1: instruction-memory write strobe, one cycle per word.
- `imem_addr` out ADDR_W: write address.
- `imem_wdata` out 24: instruction word.
- `core_reset` out 1: drives the processor core's `reset`; high except in DONE.
- `busy` out 1: a load is in progress.
- `done` out 1: the load completed and the checksum matched.
- `error` out 1: the load was aborted.
- `word_count` out 16: number of words written in the current or last load.

## Operation
- A byte is accepted when `in_valid && in_ready`. `in_ready` is decoded from the registered state only; it is 1 in LEN_HI, LEN_LO, DATA and CSUM, and 0 elsewhere.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR.
- IDLE: waits for `start`, then goes to LEN_HI. On entry to LEN_HI, clear `word_count`, the byte index, the running checksum `csum`, `done` and `error`.
- LEN_HI: the accepted byte becomes N[15:8]. Go to LEN_LO.
- LEN_LO: the accepted byte becomes N[7:0]. Then:
  - N > 2**ADDR_W: go to ERROR.
  - N == 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA:
  - Bytes arrive big-endian; word = {byte0, byte1, byte2}.
  - A 2-bit byte index counts 0, 1, 2 and then wraps to 0.
  - On acceptance of byte2, on the next cycle:
    - `imem_we`=1.
    - `imem_addr` = `word_count`[ADDR_W-1:0].
    - `imem_wdata` = assembled word.
    - `word_count` increments.
  - When the incremented count equals N, go to CSUM.
- Checksum: `csum` = XOR of every accepted byte from LEN_HI through the last DATA byte. It is updated on each acceptance.
- CSUM: the accepted byte is compared with `csum`. Equal goes to DONE; unequal goes to ERROR.
- DONE: `done`=1, `core_reset`=0, `busy`=0. Stays here until `reset` or `start`.
- ERROR: `error`=1, `core_reset`=1, `busy`=0. Stays here until `reset` or `start`.
- `start`:
  - Honoured only in IDLE, DONE or ERROR.
  - From DONE it reasserts `core_reset` in the same cycle the state moves to LEN_HI.
  - Ignored while `busy`=1.
- `busy`=1 in LEN_HI, LEN_LO, DATA and CSUM.
- `in_valid`=0 cycles (gaps) stall the FSM with no state change. `in_data` is ignored whenever no byte is accepted.
- Reset mid-load aborts immediately. Memory contents already written are not cleared; the next load overwrites them from address 0.

## Timing
- Reset values:
  - state=IDLE.
  - `in_ready`=0, `imem_we`=0, `busy`=0, `done`=0, `error`=0.
  - `core_reset`=1.
  - `imem_addr`=0, `imem_wdata`=0, `word_count`=0.
- `start` sampled at edge t moves the state to LEN_HI at t+1, so `in_ready` is high from cycle t+1.
- Maximum throughput is 1 byte/cycle. A word write strobe follows its third byte by 1 cycle, and strobes are never back-to-back.
- `imem_addr` and `imem_wdata` are valid only while `imem_we`=1. They are held at their last values otherwise.
- The cycle after the CSUM byte is accepted:
  - Match: `done`=1 and `core_reset`=0.
  - Mismatch: `error`=1.
- The last DATA word's `imem_we` is asserted in the first CSUM cycle, before `done` can rise.
- `done` and `error` are never high simultaneously.

## Test plan
- Normal load:
  - Stimulus: start; bytes 00 02 12 34 56 AB CD EF FB.
  - Response: `imem_we` pulses with addr 0 / 123456 and addr 1 / ABCDEF. `word_count`=2. `done`=1 and `core_reset`=0 the cycle after FB.
- Bad checksum: same stream with FA in place of FB -> both words written, `error`=1, `done`=0, `core_reset` stays 1, `in_ready`=0.
- Empty program: 00 00 00 -> `done`=1, no `imem_we`, `word_count`=0.
- Oversize with `ADDR_W`=8: 01 01 -> `error`=1 the cycle after LEN_LO, no DATA bytes accepted, `in_ready`=0.
- Gaps and reset:
  - Normal-load stream with `in_valid` toggling every other cycle -> identical writes and `done`.
  - Separately, assert `reset` after 4 bytes -> all outputs return to reset values. A fresh `start` plus a full stream writes from addr 0.
- Restart: `start` while in LEN_LO is ignored. `start` in DONE -> `core_reset`=1 and `done`=0 next cycle; a second load of 00 01 00 00 07 06 writes addr 0 / 000007 and sets `done`.
